// File: rtl/sampled_history_checker.sv
// -----------------------------------------------------------------------------
// sampled_history_checker
//
// Synthesizable model of the SVA sampled-value functions ($past, $stable,
// $changed, $rose, $fell) for one tracked signal. A history shift register
// captures val on every enabled edge. A per-cycle expectation selected by
// mode is checked against the pre-edge flags. Violations are reported as a
// registered one-cycle strobe, a saturating count and an optional sticky
// FAILED state.
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   rst        in   synchronous active-high reset
//   sample_en  in   take a sample of val on this edge
//   val        in   tracked signal (WIDTH bits)
//   mode       in   0 off, 1 expect change, 2 expect stable, 3 expect rise on val[0]
//   clear      in   leave FAILED and restart the warm-up (fail_count and history kept)
//   past_sel   in   history index for past_val
//   past_val   out  hist[past_sel], i.e. $past(val, past_sel+1); 0 if past_sel >= DEPTH
//   stable     out  val == hist[0]
//   changed    out  val != hist[0]
//   rose       out  !hist[0][0] && val[0]
//   fell       out  hist[0][0] && !val[0]
//   armed      out  checker is evaluating expectations
//   failed     out  checker stopped after a violation
//   fail_pulse out  one-cycle strobe on the cycle after a violating edge
//   fail_count out  saturating violation count
//   cyc_count  out  saturating count of enabled samples since reset/clear
// -----------------------------------------------------------------------------
module sampled_history_checker #(
    parameter int WIDTH        = 1,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 16,
    parameter int SKIP         = 1,
    parameter bit STOP_ON_FAIL = 1'b1,
    localparam int SEL_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] val,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic [SEL_W-1:0] past_sel,
    output logic [WIDTH-1:0] past_val,
    output logic             stable,
    output logic             changed,
    output logic             rose,
    output logic             fell,
    output logic             armed,
    output logic             failed,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] cyc_count
);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FAILED = 2'd2
    } state_e;

    localparam int WARM_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // With no warm-up the checker is armed straight out of reset/clear.
    localparam state_e INIT_ST = (SKIP == 0) ? ST_ARMED : ST_WARMUP;

    logic [WIDTH-1:0]  hist_q [DEPTH];
    logic [WIDTH-1:0]  hist_d [DEPTH];
    state_e            state_q, state_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic              pulse_q, pulse_d;
    logic              violation;

    // Sampled-value flags: current val against the most recent stored sample.
    assign stable  = (val == hist_q[0]);
    assign changed = (val != hist_q[0]);
    assign rose    = !hist_q[0][0] && val[0];
    assign fell    = hist_q[0][0] && !val[0];

    // For a non-power-of-2 DEPTH the select can point past the last entry.
    always_comb begin
        past_val = '0;
        if (int'(past_sel) < DEPTH) begin
            past_val = hist_q[past_sel];
        end
    end

    always_comb begin
        violation = 1'b0;
        unique case (mode)
            2'd1:    violation = stable;
            2'd2:    violation = changed;
            2'd3:    violation = !rose;
            default: violation = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        hist_d  = hist_q;
        state_d = state_q;
        warm_d  = warm_q;
        cyc_d   = cyc_q;
        fcnt_d  = fcnt_q;
        pulse_d = 1'b0;

        if (clear) begin
            // clear overrides the sample: no shift, no check, no pulse.
            state_d = INIT_ST;
            warm_d  = '0;
            cyc_d   = '0;
        end else if (sample_en) begin
            hist_d[0] = val;
            for (int k = 1; k < DEPTH; k++) begin
                hist_d[k] = hist_q[k-1];
            end

            if (cyc_q != CNT_MAX) begin
                cyc_d = cyc_q + 1'b1;
            end

            unique case (state_q)
                ST_WARMUP: begin
                    // The SKIP-th sample moves us to ARMED but is not itself checked.
                    if (int'(warm_q) + 1 >= SKIP) begin
                        state_d = ST_ARMED;
                    end else begin
                        warm_d = warm_q + 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (violation) begin
                        pulse_d = 1'b1;
                        if (fcnt_q != CNT_MAX) begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                        if (STOP_ON_FAIL) begin
                            state_d = ST_FAILED;
                        end
                    end
                end
                ST_FAILED: begin
                    state_d = ST_FAILED;
                end
                default: begin
                    state_d = INIT_ST;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the history array is reset on purpose: flags must compare
            // against 0 before the first sample is taken.
            for (int k = 0; k < DEPTH; k++) begin
                hist_q[k] <= '0;
            end
            state_q <= INIT_ST;
            warm_q  <= '0;
            cyc_q   <= '0;
            fcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            state_q <= state_d;
            warm_q  <= warm_d;
            cyc_q   <= cyc_d;
            fcnt_q  <= fcnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign armed      = (state_q == ST_ARMED);
    assign failed     = (state_q == ST_FAILED);
    assign fail_pulse = pulse_q;
    assign fail_count = fcnt_q;
    assign cyc_count  = cyc_q;

endmodule

// File: tb/tb_sampled_history_checker.sv
// -----------------------------------------------------------------------------
// Testbench for sampled_history_checker.
//
// Three instances share one stimulus stream:
//   A: WIDTH=4 DEPTH=4 CNT_W=16 SKIP=1 STOP_ON_FAIL=1
//   B: WIDTH=4 DEPTH=3 CNT_W=3  SKIP=1 STOP_ON_FAIL=0  (saturation, past_sel >= DEPTH)
//   C: WIDTH=4 DEPTH=4 CNT_W=16 SKIP=1 STOP_ON_FAIL=0  (continued counting)
// Inputs change on the falling edge. Expectations are pushed into two queues:
// flag expectations (checked just after the falling edge, i.e. pre-edge
// flags) and registered-output expectations (checked just after the
// following rising edge).
// -----------------------------------------------------------------------------
module tb_sampled_history_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_en;
    logic       clear;
    logic [3:0] val;
    logic [1:0] mode;
    logic [1:0] past_sel;

    always #5 clk = ~clk;

    logic [3:0]  a_past, b_past, c_past;
    logic        a_stable, a_changed, a_rose, a_fell, a_armed, a_failed, a_pulse;
    logic        b_stable, b_changed, b_rose, b_fell, b_armed, b_failed, b_pulse;
    logic        c_stable, c_changed, c_rose, c_fell, c_armed, c_failed, c_pulse;
    logic [15:0] a_fcnt, a_cyc, c_fcnt, c_cyc;
    logic [2:0]  b_fcnt, b_cyc;

    sampled_history_checker #(.WIDTH(4), .DEPTH(4), .CNT_W(16), .SKIP(1), .STOP_ON_FAIL(1'b1)) u_a (
        .clk(clk), .rst(rst), .sample_en(sample_en), .val(val), .mode(mode), .clear(clear),
        .past_sel(past_sel), .past_val(a_past), .stable(a_stable), .changed(a_changed),
        .rose(a_rose), .fell(a_fell), .armed(a_armed), .failed(a_failed),
        .fail_pulse(a_pulse), .fail_count(a_fcnt), .cyc_count(a_cyc)
    );

    sampled_history_checker #(.WIDTH(4), .DEPTH(3), .CNT_W(3), .SKIP(1), .STOP_ON_FAIL(1'b0)) u_b (
        .clk(clk), .rst(rst), .sample_en(sample_en), .val(val), .mode(mode), .clear(clear),
        .past_sel(past_sel), .past_val(b_past), .stable(b_stable), .changed(b_changed),
        .rose(b_rose), .fell(b_fell), .armed(b_armed), .failed(b_failed),
        .fail_pulse(b_pulse), .fail_count(b_fcnt), .cyc_count(b_cyc)
    );

    sampled_history_checker #(.WIDTH(4), .DEPTH(4), .CNT_W(16), .SKIP(1), .STOP_ON_FAIL(1'b0)) u_c (
        .clk(clk), .rst(rst), .sample_en(sample_en), .val(val), .mode(mode), .clear(clear),
        .past_sel(past_sel), .past_val(c_past), .stable(c_stable), .changed(c_changed),
        .rose(c_rose), .fell(c_fell), .armed(c_armed), .failed(c_failed),
        .fail_pulse(c_pulse), .fail_count(c_fcnt), .cyc_count(c_cyc)
    );

    typedef enum int {D_A, D_B, D_C} dut_e;
    typedef enum int {F_PULSE, F_FCNT, F_CYC, F_ARMED, F_FAILED,
                      F_PAST, F_STABLE, F_CHANGED, F_ROSE, F_FELL} field_e;

    typedef struct packed {
        logic [3:0]  past_val;
        logic        stable;
        logic        changed;
        logic        rose;
        logic        fell;
        logic        armed;
        logic        failed;
        logic        fail_pulse;
        logic [15:0] fail_count;
        logic [15:0] cyc_count;
    } obs_t;

    typedef struct {
        string  tag;
        dut_e   dut;
        field_e fld;
        int     exp;
    } exp_t;

    obs_t obs_a, obs_b, obs_c;
    exp_t pre_q[$];
    exp_t post_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always_comb begin
        obs_a = '{past_val: a_past, stable: a_stable, changed: a_changed, rose: a_rose,
                  fell: a_fell, armed: a_armed, failed: a_failed, fail_pulse: a_pulse,
                  fail_count: a_fcnt, cyc_count: a_cyc};
        obs_b = '{past_val: b_past, stable: b_stable, changed: b_changed, rose: b_rose,
                  fell: b_fell, armed: b_armed, failed: b_failed, fail_pulse: b_pulse,
                  fail_count: 16'(b_fcnt), cyc_count: 16'(b_cyc)};
        obs_c = '{past_val: c_past, stable: c_stable, changed: c_changed, rose: c_rose,
                  fell: c_fell, armed: c_armed, failed: c_failed, fail_pulse: c_pulse,
                  fail_count: c_fcnt, cyc_count: c_cyc};
    end

    function automatic int get_field(dut_e d, field_e f);
        obs_t o;
        case (d)
            D_A:     o = obs_a;
            D_B:     o = obs_b;
            default: o = obs_c;
        endcase
        case (f)
            F_PULSE:   return int'(o.fail_pulse);
            F_FCNT:    return int'(o.fail_count);
            F_CYC:     return int'(o.cyc_count);
            F_ARMED:   return int'(o.armed);
            F_FAILED:  return int'(o.failed);
            F_PAST:    return int'(o.past_val);
            F_STABLE:  return int'(o.stable);
            F_CHANGED: return int'(o.changed);
            F_ROSE:    return int'(o.rose);
            F_FELL:    return int'(o.fell);
            default:   return -1;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_pre(input string tag, input dut_e d, input field_e f, input int e);
        pre_q.push_back('{tag, d, f, e});
    endtask

    task automatic exp_post(input string tag, input dut_e d, input field_e f, input int e);
        post_q.push_back('{tag, d, f, e});
    endtask

    task automatic drive(input logic r, input logic en, input logic clr,
                         input logic [3:0] v, input logic [1:0] m, input logic [1:0] sel);
        @(negedge clk);
        rst       = r;
        sample_en = en;
        clear     = clr;
        val       = v;
        mode      = m;
        past_sel  = sel;
    endtask

    // Flag monitor: combinational outputs just after inputs settle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            while (pre_q.size() > 0) begin
                exp_t e;
                e = pre_q.pop_front();
                check(e.tag, get_field(e.dut, e.fld), e.exp);
            end
        end
    end

    // Registered-output monitor: state just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (post_q.size() > 0) begin
                exp_t e;
                e = post_q.pop_front();
                check(e.tag, get_field(e.dut, e.fld), e.exp);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idle_val [4] = '{9, 4, 10, 11};
        int a_hist   [4] = '{4, 3, 2, 1};

        rst = 1'b1; sample_en = 1'b0; clear = 1'b0; val = '0; mode = '0; past_sel = '0;

        // Reset state.
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        exp_post("rst_pulse",  D_A, F_PULSE,  0);
        exp_post("rst_fcnt",   D_A, F_FCNT,   0);
        exp_post("rst_cyc",    D_A, F_CYC,    0);
        exp_post("rst_armed",  D_A, F_ARMED,  0);
        exp_post("rst_failed", D_A, F_FAILED, 0);

        // Toggle 0,1,0,... under expect-change: no violations.
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 0, 4'(i % 2), 2'd1, 0);
            exp_post("tog_pulse", D_A, F_PULSE, 0);
            if (i == 0) begin
                exp_pre("tog_stable_first", D_A, F_STABLE, 1);
                exp_post("tog_armed_first", D_A, F_ARMED, 1);
            end
            if (i == 1) begin
                exp_pre("tog_rose",    D_A, F_ROSE,    1);
                exp_pre("tog_changed", D_A, F_CHANGED, 1);
            end
            if (i == 2) begin
                exp_pre("tog_fell", D_A, F_FELL, 1);
            end
        end
        exp_post("tog_fcnt",    D_A, F_FCNT,   0);
        exp_post("tog_cyc",     D_A, F_CYC,    12);
        exp_post("tog_failed",  D_A, F_FAILED, 0);
        exp_post("tog_cyc_sat", D_B, F_CYC,    7);

        // Clear, then hold val at 0 under expect-change.
        drive(0, 0, 1, 0, 0, 0);
        exp_post("clr1_armed", D_A, F_ARMED, 0);
        exp_post("clr1_cyc",   D_A, F_CYC,   0);
        for (int j = 1; j <= 10; j++) begin
            drive(0, 1, 0, 0, 2'd1, 0);
            exp_post("hold_pulse_stop",  D_A, F_PULSE,  (j == 2) ? 1 : 0);
            exp_post("hold_fcnt_stop",   D_A, F_FCNT,   (j >= 2) ? 1 : 0);
            exp_post("hold_failed_stop", D_A, F_FAILED, (j >= 2) ? 1 : 0);
            exp_post("hold_pulse_cont",  D_C, F_PULSE,  (j >= 2) ? 1 : 0);
            exp_post("hold_fcnt_cont",   D_C, F_FCNT,   j - 1);
        end
        exp_post("hold_fcnt_sat", D_B, F_FCNT, 7);
        exp_post("hold_cyc_sat",  D_B, F_CYC,  7);

        // History readback: push 1,2,3,4 then read with sampling disabled.
        for (int v = 1; v <= 4; v++) begin
            drive(0, 1, 0, 4'(v), 2'd0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 4'(idle_val[k]), 2'd0, 2'(k));
            exp_pre("past_val", D_A, F_PAST, a_hist[k]);
            exp_post("idle_pulse", D_A, F_PULSE, 0);
            exp_post("idle_cyc",   D_A, F_CYC,   14);
            if (k == 0) begin
                exp_pre("idle_changed", D_A, F_CHANGED, 1);
                exp_pre("idle_rose",    D_A, F_ROSE,    1);
            end
            if (k == 1) begin
                exp_pre("idle_stable", D_A, F_STABLE, 1);
            end
            if (k == 2) begin
                exp_pre("past_val_d3_last", D_B, F_PAST, 2);
            end
            if (k == 3) begin
                exp_pre("past_val_d3_oob", D_B, F_PAST, 0);
            end
        end

        // Expect-rise with val[0] = 1 (warm-up), 0, 1, 0, idle, 1.
        drive(0, 0, 1, 0, 2'd3, 0);
        exp_post("clr2_armed",  D_A, F_ARMED,  0);
        exp_post("clr2_failed", D_A, F_FAILED, 0);
        exp_post("clr2_fcnt",   D_A, F_FCNT,   1);
        exp_post("clr2_cyc",    D_A, F_CYC,    0);
        drive(0, 1, 0, 1, 2'd3, 0);
        exp_post("rise_armed", D_A, F_ARMED, 1);
        exp_post("rise_s1_pulse_c", D_C, F_PULSE, 0);
        drive(0, 1, 0, 0, 2'd3, 0);
        exp_pre("rise_s2_rose", D_A, F_ROSE, 0);
        exp_post("rise_s2_pulse",   D_A, F_PULSE,  1);
        exp_post("rise_s2_fcnt",    D_A, F_FCNT,   2);
        exp_post("rise_s2_failed",  D_A, F_FAILED, 1);
        exp_post("rise_s2_pulse_c", D_C, F_PULSE,  1);
        exp_post("rise_s2_fcnt_c",  D_C, F_FCNT,   10);
        drive(0, 1, 0, 1, 2'd3, 0);
        exp_post("rise_s3_pulse",   D_A, F_PULSE, 0);
        exp_post("rise_s3_pulse_c", D_C, F_PULSE, 0);
        exp_post("rise_s3_fcnt_c",  D_C, F_FCNT,  10);
        drive(0, 1, 0, 0, 2'd3, 0);
        exp_post("rise_s4_pulse",   D_A, F_PULSE, 0);
        exp_post("rise_s4_fcnt",    D_A, F_FCNT,  2);
        exp_post("rise_s4_pulse_c", D_C, F_PULSE, 1);
        exp_post("rise_s4_fcnt_c",  D_C, F_FCNT,  11);
        drive(0, 0, 0, 1, 2'd3, 0);
        exp_post("rise_idle_pulse_c", D_C, F_PULSE, 0);
        exp_post("rise_idle_fcnt_c",  D_C, F_FCNT,  11);
        drive(0, 1, 0, 1, 2'd3, 0);
        exp_post("rise_s5_pulse_c", D_C, F_PULSE, 0);
        exp_post("rise_s5_fcnt_c",  D_C, F_FCNT,  11);

        // Clear in FAILED together with a violating sample: clear wins.
        drive(0, 1, 1, 0, 2'd3, 0);
        exp_pre("clrv_rose", D_A, F_ROSE, 0);
        exp_post("clrv_armed",   D_A, F_ARMED,  0);
        exp_post("clrv_failed",  D_A, F_FAILED, 0);
        exp_post("clrv_pulse",   D_A, F_PULSE,  0);
        exp_post("clrv_fcnt",    D_A, F_FCNT,   2);
        exp_post("clrv_cyc",     D_A, F_CYC,    0);
        exp_post("clrv_pulse_c", D_C, F_PULSE,  0);
        exp_post("clrv_fcnt_c",  D_C, F_FCNT,   11);

        // Five clean toggles, then reset mid-run on a would-be violating sample.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 4'((i + 1) % 2), 2'd1, 0);
            exp_post("tog2_pulse", D_A, F_PULSE, 0);
        end
        exp_post("tog2_armed", D_A, F_ARMED, 1);
        exp_post("tog2_cyc",   D_A, F_CYC,   5);
        drive(1, 1, 0, 1, 2'd1, 0);
        exp_post("mrst_pulse",  D_A, F_PULSE,  0);
        exp_post("mrst_fcnt",   D_A, F_FCNT,   0);
        exp_post("mrst_cyc",    D_A, F_CYC,    0);
        exp_post("mrst_armed",  D_A, F_ARMED,  0);
        exp_post("mrst_failed", D_A, F_FAILED, 0);
        exp_post("mrst_fcnt_c", D_C, F_FCNT,   0);
        drive(0, 1, 0, 0, 2'd1, 0);
        exp_pre("mrst_past",   D_A, F_PAST,   0);
        exp_pre("mrst_stable", D_A, F_STABLE, 1);
        exp_post("mrst_s1_pulse", D_A, F_PULSE, 0);
        exp_post("mrst_s1_armed", D_A, F_ARMED, 1);
        exp_post("mrst_s1_cyc",   D_A, F_CYC,   1);
        drive(0, 1, 0, 0, 2'd1, 0);
        exp_post("mrst_s2_pulse",  D_A, F_PULSE,  1);
        exp_post("mrst_s2_fcnt",   D_A, F_FCNT,   1);
        exp_post("mrst_s2_failed", D_A, F_FAILED, 1);

        drive(0, 0, 0, 0, 2'd0, 0);
        @(posedge clk);
        #3;
        check("scoreboard_drained", pre_q.size() + post_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
